// File: rtl/ram_write_scheduler_pkg.sv
// Shared types for the dual-port RAM write scheduler.
// Request bundle and address-compare helper.
package ram_write_scheduler_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] addr;
    logic [DATA_W_DEF-1:0] data;
  } wr_req_t;

  function automatic logic same_addr(
    wr_req_t a,
    wr_req_t b
  );
    return a.addr == b.addr;
  endfunction

endpackage

// File: rtl/wr_hold_slot.sv
// One-entry holding register for a write request that lost arbitration.
// Load takes priority over clear.
module wr_hold_slot
  import ram_write_scheduler_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    load,
  input  logic    clear,
  input  wr_req_t req_in,
  output logic    valid,
  output wr_req_t req_out
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid   <= 1'b0;
      req_out <= '0;
    end else if (load) begin
      valid   <= 1'b1;
      req_out <= req_in;
    end else if (clear) begin
      valid   <= 1'b0;
    end
  end

endmodule

// File: rtl/ram_write_scheduler.sv
// Two-stream write scheduler feeding a dual-write-port RAM.
// Define RAM_WRITE_SCHEDULER_COALESCE_EN to merge conflicts instead.
module ram_write_scheduler
  import ram_write_scheduler_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  output logic              in0_ready,
  input  logic [ADDR_W-1:0] in0_addr,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in1_valid,
  output logic              in1_ready,
  input  logic [ADDR_W-1:0] in1_addr,
  input  logic [DATA_W-1:0] in1_data,
  output logic              wen0,
  output logic [ADDR_W-1:0] waddr0,
  output logic [DATA_W-1:0] wdata0,
  output logic              wen1,
  output logic [ADDR_W-1:0] waddr1,
  output logic [DATA_W-1:0] wdata1,
  output logic [CNT_W-1:0]  collisions
);

  wr_req_t req0, req1;
  wr_req_t slot0, slot1;
  wr_req_t cand0, cand1;
  logic    slot_v0, slot_v1;
  logic    acc0, acc1;
  logic    c0_v, c1_v;
  logic    conflict;
  logic    lose0, lose1;
  logic    load0, load1;
  logic    iss0, iss1;

  assign req0 = '{addr: ADDR_W_DEF'(in0_addr),
                  data: DATA_W_DEF'(in0_data)};
  assign req1 = '{addr: ADDR_W_DEF'(in1_addr),
                  data: DATA_W_DEF'(in1_data)};

  always_comb begin
    acc0     = in0_valid & in0_ready;
    acc1     = in1_valid & in1_ready;
    c0_v     = slot_v0 | acc0;
    c1_v     = slot_v1 | acc1;
    cand0    = slot_v0 ? slot0 : req0;
    cand1    = slot_v1 ? slot1 : req1;
    conflict = c0_v & c1_v & same_addr(cand0, cand1);
`ifdef RAM_WRITE_SCHEDULER_COALESCE_EN
    // the younger write survives; the older one is overwritten anyway
    lose0    = conflict & ~slot_v1;
    lose1    = conflict & slot_v1;
    load0    = 1'b0;
    load1    = 1'b0;
`else
    // a slotted request is older, so the fresh one yields
    lose0    = conflict & slot_v1;
    lose1    = conflict & ~slot_v1;
    load0    = lose0;
    load1    = lose1;
`endif
    iss0     = c0_v & ~lose0;
    iss1     = c1_v & ~lose1;
  end

  wr_hold_slot u_slot0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load0),
    .clear   (slot_v0),
    .req_in  (req0),
    .valid   (slot_v0),
    .req_out (slot0)
  );

  wr_hold_slot u_slot1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load1),
    .clear   (slot_v1),
    .req_in  (req1),
    .valid   (slot_v1),
    .req_out (slot1)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in0_ready <= 1'b0;
      in1_ready <= 1'b0;
      wen0      <= 1'b0;
      wen1      <= 1'b0;
      waddr0    <= '0;
      wdata0    <= '0;
      waddr1    <= '0;
      wdata1    <= '0;
    end else begin
      in0_ready <= ~load0;
      in1_ready <= ~load1;
      wen0      <= iss0;
      wen1      <= iss1;
      if (iss0) begin
        waddr0 <= ADDR_W'(cand0.addr);
        wdata0 <= DATA_W'(cand0.data);
      end
      if (iss1) begin
        waddr1 <= ADDR_W'(cand1.addr);
        wdata1 <= DATA_W'(cand1.data);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      collisions <= '0;
    end else if (conflict && (collisions != '1)) begin
      collisions <= collisions + 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_write_scheduler.sv
// Scoreboard bench for ram_write_scheduler: expected RAM writes are
// queued per port with their issue cycle; a negedge monitor checks them.
module tb_ram_write_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in0_valid, in1_valid;
  logic        in0_ready, in1_ready;
  logic [7:0]  in0_addr, in1_addr;
  logic [31:0] in0_data, in1_data;
  logic        wen0, wen1;
  logic [7:0]  waddr0, waddr1;
  logic [31:0] wdata0, wdata1;
  logic [3:0]  collisions;

  typedef struct {
    int          cyc;
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  logic [31:0] mem [256];
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  ram_write_scheduler #(
    .ADDR_W (8),
    .DATA_W (32),
    .CNT_W  (4)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in0_valid  (in0_valid),
    .in0_ready  (in0_ready),
    .in0_addr   (in0_addr),
    .in0_data   (in0_data),
    .in1_valid  (in1_valid),
    .in1_ready  (in1_ready),
    .in1_addr   (in1_addr),
    .in1_data   (in1_data),
    .wen0       (wen0),
    .waddr0     (waddr0),
    .wdata0     (wdata0),
    .wen1       (wen1),
    .waddr1     (waddr1),
    .wdata1     (wdata1),
    .collisions (collisions)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic drive(logic v0, logic [7:0] a0, logic [31:0] d0,
                       logic v1, logic [7:0] a1, logic [31:0] d1);
    in0_valid = v0; in0_addr = a0; in0_data = d0;
    in1_valid = v1; in1_addr = a1; in1_data = d1;
  endtask

  task automatic idle();
    drive(1'b0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp0(int c, logic [7:0] a, logic [31:0] d);
    q0.push_back('{c, a, d});
  endtask

  task automatic exp1(int c, logic [7:0] a, logic [31:0] d);
    q1.push_back('{c, a, d});
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (wen0) begin
      if (q0.size() == 0) begin
        chk("port0 unexpected wen", wen0, 1'b0);
      end else begin
        e = q0.pop_front();
        chk("port0 cycle", cyc, e.cyc);
        chk("port0 addr", waddr0, e.addr);
        chk("port0 data", wdata0, e.data);
      end
      mem[waddr0] = wdata0;
    end else if (q0.size() != 0 && q0[0].cyc <= cyc) begin
      chk("port0 missing wen", wen0, 1'b1);
      void'(q0.pop_front());
    end
    if (wen1) begin
      if (q1.size() == 0) begin
        chk("port1 unexpected wen", wen1, 1'b0);
      end else begin
        e = q1.pop_front();
        chk("port1 cycle", cyc, e.cyc);
        chk("port1 addr", waddr1, e.addr);
        chk("port1 data", wdata1, e.data);
      end
      mem[waddr1] = wdata1;
    end else if (q1.size() != 0 && q1[0].cyc <= cyc) begin
      chk("port1 missing wen", wen1, 1'b1);
      void'(q1.pop_front());
    end
    if (wen0 && wen1)
      chk("dual write same addr", waddr0 == waddr1, 1'b0);
  end

  initial begin : stim
    int k;
    logic [7:0] a;
`ifdef RAM_WRITE_SCHEDULER_COALESCE_EN
    logic coal = 1'b1;
`else
    logic coal = 1'b0;
`endif
    rst_n = 1'b0;
    drive(1'b1, 8'h77, 32'h1234, 1'b0, 8'h0, 32'h0);
    repeat (3) step();
    chk("reset wen0", wen0, 0);
    chk("reset wen1", wen1, 0);
    chk("reset in0_ready", in0_ready, 0);
    chk("reset in1_ready", in1_ready, 0);
    chk("reset collisions", collisions, 0);
    rst_n = 1'b1;
    idle();
    step();
    chk("release in0_ready", in0_ready, 1);
    chk("release in1_ready", in1_ready, 1);

    // distinct addresses, full throughput
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 8'h10, 32'hAAAA0000 + i, 1'b1, 8'h20, 32'hBBBB0000 + i);
      exp0(cyc + 1, 8'h10, 32'hAAAA0000 + i);
      exp1(cyc + 1, 8'h20, 32'hBBBB0000 + i);
      step();
      chk("stream in0_ready", in0_ready, 1);
      chk("stream in1_ready", in1_ready, 1);
    end
    idle();
    step();
    chk("stream collisions", collisions, 0);

    // same-address collision, both fresh
    k = cyc;
    drive(1'b1, 8'h05, 32'h11, 1'b1, 8'h05, 32'h22);
    if (coal) begin
      exp1(k + 1, 8'h05, 32'h22);
    end else begin
      exp0(k + 1, 8'h05, 32'h11);
      exp1(k + 2, 8'h05, 32'h22);
    end
    step();
    idle();
    chk("coll in1_ready", in1_ready, coal);
    chk("coll in0_ready", in0_ready, 1);
    chk("coll count", collisions, 1);
    step();
    step();
    chk("coll mem 05", mem[5], 32'h22);

    // slotted request beats a fresh conflicting one
    k = cyc;
    drive(1'b1, 8'h05, 32'h11, 1'b1, 8'h05, 32'h22);
    if (coal) begin
      exp1(k + 1, 8'h05, 32'h22);
      exp0(k + 2, 8'h05, 32'h33);
    end else begin
      exp0(k + 1, 8'h05, 32'h11);
      exp1(k + 2, 8'h05, 32'h22);
      exp0(k + 3, 8'h05, 32'h33);
    end
    step();
    drive(1'b1, 8'h05, 32'h33, 1'b0, 8'h0, 32'h0);
    step();
    idle();
    chk("age in0_ready", in0_ready, coal);
    chk("age in1_ready", in1_ready, 1);
    chk("age count", collisions, coal ? 2 : 3);
    step();
    step();
    chk("age mem 05", mem[5], 32'h33);
    chk("age in0_ready back", in0_ready, 1);

    // reset while the loser sits in its slot
    k = cyc;
    drive(1'b1, 8'h40, 32'h55, 1'b1, 8'h40, 32'h66);
    if (coal) exp1(k + 1, 8'h40, 32'h66);
    else      exp0(k + 1, 8'h40, 32'h55);
    step();
    rst_n = 1'b0;
    idle();
    step();
    chk("midrst wen1", wen1, 0);
    chk("midrst count", collisions, 0);
    chk("midrst in1_ready", in1_ready, 0);
    rst_n = 1'b1;
    step();
    chk("midrst slot empty", in1_ready, 1);
    chk("midrst wen1 after", wen1, 0);

    // counter saturation
    for (int i = 0; i < 20; i++) begin
      k = cyc;
      a = 8'h80 + 8'(i);
      drive(1'b1, a, 32'h1000 + i, 1'b1, a, 32'h2000 + i);
      if (coal) begin
        exp1(k + 1, a, 32'h2000 + i);
      end else begin
        exp0(k + 1, a, 32'h1000 + i);
        exp1(k + 2, a, 32'h2000 + i);
      end
      step();
      idle();
      step();
    end
    chk("sat count", collisions, 4'hF);
    repeat (3) step();
    chk("sat count hold", collisions, 4'hF);
    chk("end in0_ready", in0_ready, 1);
    chk("end in1_ready", in1_ready, 1);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_write_scheduler.md
Name: ram_write_scheduler

Overview:
- Sits directly upstream of the dual-write-port block RAM.
- Takes two independent valid/ready write request streams and drives the RAM's wen0/waddr0/wdata0 and wen1/waddr1/wdata1 ports.
- Guarantees the RAM never sees both write enables asserted to the same address in one cycle, which it forbids.
- Same-address collisions are serialised in order (oldest first) through a one-entry slot per channel; a saturating collision counter is kept for debug.

Parameters:
- ADDR_W, 8, write address width (matches RAM depth 256).
- DATA_W, 32, write data width.
- CNT_W, 16, width of the saturating collision counter.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in0_valid  in  1  channel 0 request valid.
- in0_ready  out  1  channel 0 can accept (registered).
- in0_addr  in  ADDR_W  channel 0 write address.
- in0_data  in  DATA_W  channel 0 write data.
- in1_valid, in1_ready, in1_addr, in1_data: as channel 0, for channel 1.
- wen0  out  1  to RAM write port 0 enable (registered).
- waddr0  out  ADDR_W  to RAM write port 0 address.
- wdata0  out  DATA_W  to RAM write port 0 data.
- wen1, waddr1, wdata1: as port 0, for RAM write port 1. Channel k always maps to port k.
- collisions  out  CNT_W  saturating count of same-address conflicts since reset.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low, sampled only on the rising edge of clk.
- Reset values (rst_n low at an edge):
  - in0_ready = in1_ready = 0; wen0 = wen1 = 0; waddr/wdata = 0; collisions = 0.
  - Both slots are emptied. Any request in flight or held in a slot is discarded; reset mid-collision drops the pending write.
- First cycle after reset release: readies rise to 1.
- Handshake: a request is accepted when inK_valid && inK_ready at an edge. Inputs must hold while valid && !ready.
- Candidates each cycle: candK = slotK if slot_validK, else the accepted input K, else none.
- No conflict (at most one candidate, or addresses differ):
  - Every candidate issues; wenK/waddrK/wdataK are registered at this edge.
  - Accept-to-RAM latency is 1 cycle; full throughput on both channels.
  - An issued slot is cleared.
- Conflict (both candidates present, addresses equal):
  - Winner is the channel whose candidate comes from its slot (the older request). If neither does, channel 0 wins.
  - The winner issues. The loser is captured into its slot; wen on the loser's port is 0 this cycle.
  - The loser issues on the next cycle, still on its own port, and beats any fresh conflicting request on the other channel.
  - collisions increments by 1 and saturates at all-ones (no wrap).
- At most one slot is ever occupied.
- inK_ready is registered as !(next slot_validK). A collision therefore deasserts the loser's ready for exactly one cycle.
- Final RAM content at the address always equals in-order execution: the older request first, channel 0 before channel 1 when both arrive together.
- Writes to different addresses never stall.

Optional Feature:
- Macro: RAM_WRITE_SCHEDULER_COALESCE_EN.
- Defined: on a conflict, both candidates are consumed in the same cycle and only the younger is issued. Younger is channel 1 when both are fresh; otherwise the fresh one. The older write is dropped because the younger overwrites it.
  - Slots never fill, so readies stay 1 after reset.
  - collisions counts coalesce events.
- Undefined: serialising behaviour as described above.

Decomposition:
- Package ram_write_scheduler_pkg:
  - ADDR_W/DATA_W defaults.
  - Struct wr_req_t {addr, data}.
  - Function same_addr(wr_req_t a, wr_req_t b).
- One sub-module: wr_hold_slot, a one-entry holding register with valid. Ports: load, clear, req in/out; sync active-low reset. Instantiated twice.

Test Plan:
- Reset: rst_n low 3 cycles with in0_valid=1 → wen0=wen1=0, readies 0, collisions=0. One cycle after release, readies = 1.
- Distinct addresses: ch0 (0x10,0xAAAA0000) and ch1 (0x20,0xBBBB0000) every cycle for 8 cycles → each request appears on its port one cycle later; readies never drop; collisions=0.
- Collision, both fresh: ch0 (0x05,0x11) and ch1 (0x05,0x22) in cycle t.
  - t+1: wen0=1 with 0x11, wen1=0.
  - t+2: wen1=1 with 0x22.
  - in1_ready=0 during t+1; collisions=1; RAM read of 0x05 returns 0x22.
- Age priority: in cycle t+1 of the previous case, ch0 presents (0x05,0x33) → t+2 issues ch1's 0x22 only; t+3 issues 0x33 on port 0; final value 0x33.
- Reset mid-operation: collision at t, then rst_n low at t+1 → no wen1 at t+2; slot empty; collisions=0.
- Saturation: with CNT_W=4, force 20 collisions → collisions holds 0xF. With COALESCE_EN defined, the single-cycle collision case gives t+1 wen0=0, wen1=1 with 0x22, and readies stay 1.
